// File: rtl/vram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vram_pkg
// Description : Shared definitions for the vector RAM responder: default
//               geometry, derived beat/line widths, FSM state encoding and a
//               width helper usable in parameter expressions.
// Revision    : 1.0 - initial release
// ============================================================================
package vram_pkg;

    // Default geometry of the vector RAM port and its backing SRAM.
    localparam int unsigned VRAM_DW_DEF = 512;
    localparam int unsigned VRAM_AW_DEF = 64;
    localparam int unsigned SRAM_DW_DEF = 64;
    localparam int unsigned DEPTH_DEF   = 256;

    // Bit width needed to index v items, never less than one bit so that
    // degenerate configurations still yield legal vector declarations.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    // Derived widths for the default geometry.
    localparam int unsigned BEATS      = VRAM_DW_DEF / SRAM_DW_DEF;
    localparam int unsigned BEAT_W     = clog2_min1(BEATS);
    localparam int unsigned LINE_W     = clog2_min1(DEPTH_DEF);
    localparam int unsigned LINE_OFF_W = $clog2(VRAM_DW_DEF / 8);

    // Responder FSM encoding.
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_WR     = 2'd1;
    localparam state_t S_RD     = 2'd2;
    localparam state_t S_RDLAST = 2'd3;

endpackage : vram_pkg
`default_nettype wire

// File: rtl/vram_sram_bank.sv
`default_nettype none
// ============================================================================
// Module      : vram_sram_bank
// Description : Single-port (1RW) SRAM model of WORDS x DW bits with a per-bit
//               write mask and a synchronous read. Contents are not reset.
// Ports       : clk    - clock, rising edge
//               en     - access enable for this cycle
//               we     - 1 = masked write, 0 = read
//               addr   - word address
//               wdata  - write data
//               wmask  - per-bit write enable, 1 = write
//               rdata  - read data, valid the cycle after a read is issued
// Revision    : 1.0 - initial release
// ============================================================================
module vram_sram_bank
    import vram_pkg::*;
#(
    parameter int unsigned DW    = 64,
    parameter int unsigned WORDS = 2048
) (
    input  logic                         clk,
    input  logic                         en,
    input  logic                         we,
    input  logic [clog2_min1(WORDS)-1:0] addr,
    input  logic [DW-1:0]                wdata,
    input  logic [DW-1:0]                wmask,
    output logic [DW-1:0]                rdata
);

    logic [DW-1:0] r_mem [WORDS];
    logic [DW-1:0] r_rdata;

    // Read data holds its last value when no read is issued.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                r_mem[addr] <= (r_mem[addr] & ~wmask) | (wdata & wmask);
            end else begin
                r_rdata <= r_mem[addr];
            end
        end
    end

    assign rdata = r_rdata;

endmodule : vram_sram_bank
`default_nettype wire

// File: rtl/vram_responder.sv
`default_nettype none
// ============================================================================
// Module      : vram_responder
// Description : Memory-side responder for the vector RAM port. Each full-line
//               request is serialised into BEATS sequential accesses of a
//               narrower single-port SRAM; reads are reassembled into a line.
// Ports       : clk           - clock, rising edge
//               rst           - asynchronous reset, active low
//               vram_ren_i    - read request
//               vram_wen_i    - write request (wins over a read)
//               vram_addr_i   - byte address of the line
//               vram_mask_i   - per-bit write enable, 1 = write
//               vram_din_i    - write data line
//               vram_ready_o  - idle; a request is accepted this cycle
//               vram_rvalid_o - one-cycle pulse, vram_dout_o holds a read
//               vram_dout_o   - read data line, held until the next read
// Revision    : 1.0 - initial release
// ============================================================================
module vram_responder
    import vram_pkg::*;
#(
    parameter int unsigned VRAM_DW = VRAM_DW_DEF,
    parameter int unsigned VRAM_AW = VRAM_AW_DEF,
    parameter int unsigned SRAM_DW = SRAM_DW_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vram_ren_i,
    input  logic               vram_wen_i,
    input  logic [VRAM_AW-1:0] vram_addr_i,
    input  logic [VRAM_DW-1:0] vram_mask_i,
    input  logic [VRAM_DW-1:0] vram_din_i,
    output logic               vram_ready_o,
    output logic               vram_rvalid_o,
    output logic [VRAM_DW-1:0] vram_dout_o
);

    localparam int unsigned C_BEATS      = VRAM_DW / SRAM_DW;
    localparam int unsigned C_BEAT_W     = clog2_min1(C_BEATS);
    localparam int unsigned C_LINE_W     = clog2_min1(DEPTH);
    localparam int unsigned C_LINE_OFF_W = $clog2(VRAM_DW / 8);
    localparam int unsigned C_WORDS      = DEPTH * C_BEATS;
    localparam int unsigned C_SRAM_AW    = clog2_min1(C_WORDS);
    localparam logic [C_BEAT_W-1:0] C_LAST_BEAT = C_BEAT_W'(C_BEATS - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [C_BEAT_W-1:0]   r_cnt;
    logic [C_LINE_W-1:0]   r_line;
    logic [VRAM_DW-1:0]    r_mask;
    logic [VRAM_DW-1:0]    r_din;
    logic [VRAM_DW-1:0]    r_line_asm;
    logic [VRAM_DW-1:0]    r_dout;
    logic                  r_rvalid;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_sram_en;
    logic                  w_sram_we;
    logic [C_SRAM_AW-1:0]  w_sram_addr;
    logic [SRAM_DW-1:0]    w_sram_wdata;
    logic [SRAM_DW-1:0]    w_sram_wmask;
    logic [SRAM_DW-1:0]    w_sram_rdata;
    logic [VRAM_DW-1:0]    w_line_next;
    logic                  w_unused_addr;

    // Only the line-index field of the address matters: offset bits select a
    // byte inside the line and upper bits wrap modulo DEPTH.
    assign w_unused_addr = ^vram_addr_i;

    assign w_accept = w_ready & (vram_ren_i | vram_wen_i);
    assign w_last   = (r_cnt == C_LAST_BEAT);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. A write wins when both requests are raised.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (vram_wen_i) begin
                    w_state_next = S_WR;
                end else if (vram_ren_i) begin
                    w_state_next = S_RD;
                end
            end
            S_WR: begin
                if (w_last) begin
                    w_state_next = S_IDLE;
                end
            end
            S_RD: begin
                if (w_last) begin
                    w_state_next = S_RDLAST;
                end
            end
            S_RDLAST: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. One SRAM beat per cycle in WR and RD; RDLAST only
    // collects the final returned beat.
    // ------------------------------------------------------------------
    always_comb begin
        w_ready   = 1'b0;
        w_sram_en = 1'b0;
        w_sram_we = 1'b0;
        case (r_state)
            S_IDLE: w_ready = 1'b1;
            S_WR: begin
                w_sram_en = 1'b1;
                w_sram_we = 1'b1;
            end
            S_RD:    w_sram_en = 1'b1;
            default: w_ready   = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Beat counter and request capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_line <= '0;
            r_mask <= '0;
            r_din  <= '0;
        end else begin
            if ((r_state == S_WR || r_state == S_RD) && !w_last) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
            if (w_accept) begin
                r_line <= vram_addr_i[C_LINE_OFF_W +: C_LINE_W];
                r_mask <= vram_mask_i;
                r_din  <= vram_din_i;
            end
        end
    end

    // Word address = line * BEATS + beat.
    assign w_sram_addr  = C_SRAM_AW'(r_line * C_BEATS + r_cnt);
    assign w_sram_wdata = r_din[r_cnt * SRAM_DW +: SRAM_DW];
    assign w_sram_wmask = r_mask[r_cnt * SRAM_DW +: SRAM_DW];

    // ------------------------------------------------------------------
    // Line assembly: returned beats enter at the top and shift down, so
    // after BEATS insertions beat 0 sits in the lowest slice.
    // ------------------------------------------------------------------
    generate
        if (C_BEATS > 1) begin : g_multi_beat
            assign w_line_next = {w_sram_rdata, r_line_asm[VRAM_DW-1:SRAM_DW]};
        end else begin : g_single_beat
            assign w_line_next = w_sram_rdata;
        end
    endgenerate

    // Beat k-1 is on the SRAM output while beat k is issued, so the shift
    // runs on every RD cycle except the first; RDLAST adds the last beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_line_asm <= '0;
            r_dout     <= '0;
            r_rvalid   <= 1'b0;
        end else begin
            r_rvalid <= (r_state == S_RDLAST);
            if (r_state == S_RD && r_cnt != '0) begin
                r_line_asm <= w_line_next;
            end
            if (r_state == S_RDLAST) begin
                r_dout <= w_line_next;
            end
        end
    end

    vram_sram_bank #(
        .DW    (SRAM_DW),
        .WORDS (C_WORDS)
    ) u_sram_bank (
        .clk   (clk),
        .en    (w_sram_en),
        .we    (w_sram_we),
        .addr  (w_sram_addr),
        .wdata (w_sram_wdata),
        .wmask (w_sram_wmask),
        .rdata (w_sram_rdata)
    );

    assign vram_ready_o  = w_ready;
    assign vram_rvalid_o = r_rvalid;
    assign vram_dout_o   = r_dout;

endmodule : vram_responder
`default_nettype wire

// File: tb/tb_vram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_responder
// Description : Directed self-checking testbench for vram_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic         vram_ren_i;
    logic         vram_wen_i;
    logic [63:0]  vram_addr_i;
    logic [511:0] vram_mask_i;
    logic [511:0] vram_din_i;
    logic         vram_ready_o;
    logic         vram_rvalid_o;
    logic [511:0] vram_dout_o;

    int errors = 0;
    int checks = 0;

    logic [511:0] pat_a;
    logic [511:0] pat_b;
    logic [511:0] pat_c;
    logic [511:0] ones;

    always #5 clk = ~clk;

    vram_responder u_dut (
        .clk           (clk),
        .rst           (rst),
        .vram_ren_i    (vram_ren_i),
        .vram_wen_i    (vram_wen_i),
        .vram_addr_i   (vram_addr_i),
        .vram_mask_i   (vram_mask_i),
        .vram_din_i    (vram_din_i),
        .vram_ready_o  (vram_ready_o),
        .vram_rvalid_o (vram_rvalid_o),
        .vram_dout_o   (vram_dout_o)
    );

    // Presents a request for exactly one rising edge; returns at edge + 1.
    task automatic issue(input logic r, input logic w, input logic [63:0] a,
                         input logic [511:0] m, input logic [511:0] d);
        @(negedge clk);
        vram_ren_i  = r;
        vram_wen_i  = w;
        vram_addr_i = a;
        vram_mask_i = m;
        vram_din_i  = d;
        @(posedge clk);
        #1;
        vram_ren_i  = 1'b0;
        vram_wen_i  = 1'b0;
        vram_addr_i = '0;
        vram_mask_i = '0;
        vram_din_i  = '0;
    endtask

    // Issues a write, counts cycles with ready low and any rvalid pulses.
    task automatic write_line(input logic [63:0] a, input logic [511:0] m,
                              input logic [511:0] d, input logic also_ren,
                              output int busy, output int pulses);
        issue(also_ren, 1'b1, a, m, d);
        busy   = 0;
        pulses = 0;
        for (int n = 0; n < 30; n++) begin
            if (vram_rvalid_o) pulses++;
            if (vram_ready_o) break;
            busy++;
            @(posedge clk);
            #1;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            if (vram_rvalid_o) pulses++;
        end
    endtask

    // Issues a read; lat = edges from acceptance to rvalid (-1 on timeout).
    task automatic read_line(input logic [63:0] a, output int lat,
                             output logic [511:0] data, output logic drop_ok);
        issue(1'b1, 1'b0, a, '0, '0);
        lat     = -1;
        data    = '0;
        drop_ok = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            if (vram_rvalid_o) begin
                lat  = n;
                data = vram_dout_o;
                break;
            end
        end
        if (lat > 0) begin
            @(posedge clk);
            #1;
            drop_ok = !vram_rvalid_o;
        end
    endtask

    task automatic test_reset();
        int           pulses;
        rst         = 1'b0;
        vram_ren_i  = 1'b0;
        vram_wen_i  = 1'b0;
        vram_addr_i = '0;
        vram_mask_i = '0;
        vram_din_i  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (vram_ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", vram_ready_o);
        end
        checks++;
        if (vram_rvalid_o !== 1'b0) begin
            errors++; $display("FAIL reset_rvalid: got %b want 0", vram_rvalid_o);
        end
        checks++;
        if (vram_dout_o !== '0) begin
            errors++; $display("FAIL reset_dout: got %h want 0", vram_dout_o);
        end
        rst = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (vram_rvalid_o) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL idle_no_rvalid: got %0d pulses want 0", pulses);
        end
        // Asynchronous assertion in the middle of a write (line 5, unused later).
        issue(1'b0, 1'b1, 64'h140, ones, {8{64'h5555_5555_5555_5555}});
        checks++;
        if (vram_ready_o !== 1'b0) begin
            errors++; $display("FAIL write_busy: got ready=%b want 0", vram_ready_o);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (vram_ready_o !== 1'b1 || vram_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got ready=%b rvalid=%b want ready=1 rvalid=0",
                     vram_ready_o, vram_rvalid_o);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_full_write_read();
        int           busy, pulses, lat;
        logic [511:0] data;
        logic         drop_ok;
        write_line(64'h40, ones, pat_a, 1'b0, busy, pulses);
        checks++;
        if (busy != 8) begin
            errors++; $display("FAIL write_busy_cycles: got %0d want 8", busy);
        end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL write_no_rvalid: got %0d want 0", pulses);
        end
        read_line(64'h40, lat, data, drop_ok);
        checks++;
        if (lat != 9) begin
            errors++; $display("FAIL read_latency: got %0d want 9", lat);
        end
        checks++;
        if (data !== pat_a) begin
            errors++; $display("FAIL read_data: got %h want %h", data, pat_a);
        end
        checks++;
        if (drop_ok !== 1'b1) begin
            errors++; $display("FAIL rvalid_single_cycle: got drop=%b want 1", drop_ok);
        end
    endtask

    task automatic test_masked_write();
        int           busy, pulses, lat;
        logic [511:0] data;
        logic [511:0] expect_line;
        logic         drop_ok;
        expect_line = {{448{1'b1}}, 64'h0};
        write_line(64'h80, ones, ones, 1'b0, busy, pulses);
        write_line(64'h80, {448'h0, {64{1'b1}}}, '0, 1'b0, busy, pulses);
        read_line(64'h80, lat, data, drop_ok);
        checks++;
        if (data !== expect_line) begin
            errors++; $display("FAIL masked_write: got %h want %h", data, expect_line);
        end
        // An all-zero mask keeps the bus busy the full time and changes nothing.
        write_line(64'h80, '0, {8{64'h0123_4567_89AB_CDEF}}, 1'b0, busy, pulses);
        checks++;
        if (busy != 8) begin
            errors++; $display("FAIL zero_mask_busy: got %0d want 8", busy);
        end
        read_line(64'h80, lat, data, drop_ok);
        checks++;
        if (data !== expect_line) begin
            errors++; $display("FAIL zero_mask_data: got %h want %h", data, expect_line);
        end
    endtask

    task automatic test_wrap();
        int           busy, pulses, lat;
        logic [511:0] data;
        logic         drop_ok;
        write_line(64'h403F, ones, pat_b, 1'b0, busy, pulses);
        read_line(64'h0, lat, data, drop_ok);
        checks++;
        if (data !== pat_b) begin
            errors++; $display("FAIL wrap_line0: got %h want %h", data, pat_b);
        end
        read_line(64'h40, lat, data, drop_ok);
        checks++;
        if (data !== pat_a) begin
            errors++; $display("FAIL wrap_line1_intact: got %h want %h", data, pat_a);
        end
    endtask

    task automatic test_simul_and_busy();
        int           busy, pulses, lat;
        logic [511:0] data;
        logic         drop_ok;
        write_line(64'hC0, ones, pat_c, 1'b1, busy, pulses);
        checks++;
        if (busy != 8 || pulses != 0) begin
            errors++;
            $display("FAIL ren_wen_is_write: got busy=%0d pulses=%0d want 8 0", busy, pulses);
        end
        read_line(64'hC0, lat, data, drop_ok);
        checks++;
        if (data !== pat_c) begin
            errors++; $display("FAIL ren_wen_data: got %h want %h", data, pat_c);
        end
        // A read raised while busy must be dropped.
        issue(1'b1, 1'b0, 64'hC0, '0, '0);
        @(negedge clk);
        vram_ren_i  = 1'b1;
        vram_addr_i = 64'h0;
        pulses = 0;
        data   = '0;
        for (int n = 1; n <= 25; n++) begin
            @(posedge clk);
            #1;
            if (n == 2) begin
                vram_ren_i  = 1'b0;
                vram_addr_i = '0;
            end
            if (vram_rvalid_o) begin
                pulses++;
                data = vram_dout_o;
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++; $display("FAIL busy_drop_pulses: got %0d want 1", pulses);
        end
        checks++;
        if (data !== pat_c) begin
            errors++; $display("FAIL busy_drop_data: got %h want %h", data, pat_c);
        end
    endtask

    task automatic test_back_to_back();
        int           lat, busy, pulses;
        logic [511:0] data;
        issue(1'b1, 1'b0, 64'h40, '0, '0);
        lat = -1;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            if (vram_rvalid_o) begin
                lat = n;
                break;
            end
        end
        checks++;
        if (lat != 9 || vram_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: got lat=%0d ready=%b want 9 1", lat, vram_ready_o);
        end
        // Request during the rvalid cycle is accepted on the next edge.
        @(negedge clk);
        vram_ren_i  = 1'b1;
        vram_addr_i = 64'hC0;
        @(posedge clk);
        #1;
        vram_ren_i  = 1'b0;
        vram_addr_i = '0;
        checks++;
        if (vram_ready_o !== 1'b0 || vram_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: got ready=%b rvalid=%b want 0 0",
                     vram_ready_o, vram_rvalid_o);
        end
        lat  = -1;
        data = '0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            if (vram_rvalid_o) begin
                lat  = n;
                data = vram_dout_o;
                break;
            end
        end
        checks++;
        if (lat != 9 || data !== pat_c) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d data=%h want 9 %h", lat, data, pat_c);
        end
        // Writes never touch the read data output.
        write_line(64'hC0, ones, pat_a, 1'b0, busy, pulses);
        checks++;
        if (vram_dout_o !== pat_c) begin
            errors++; $display("FAIL dout_hold: got %h want %h", vram_dout_o, pat_c);
        end
    endtask

    task automatic test_reset_mid_read();
        int           pulses, lat;
        logic [511:0] data;
        logic         drop_ok;
        issue(1'b1, 1'b0, 64'h40, '0, '0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (vram_ready_o !== 1'b1 || vram_rvalid_o !== 1'b0 || vram_dout_o !== '0) begin
            errors++;
            $display("FAIL reset_mid_read: got ready=%b rvalid=%b dout=%h want 1 0 0",
                     vram_ready_o, vram_rvalid_o, vram_dout_o);
        end
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (vram_rvalid_o) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL reset_no_rvalid: got %0d want 0", pulses);
        end
        read_line(64'h40, lat, data, drop_ok);
        checks++;
        if (lat != 9 || data !== pat_a) begin
            errors++;
            $display("FAIL read_after_reset: got lat=%0d data=%h want 9 %h", lat, data, pat_a);
        end
    endtask

    initial begin
        ones = '1;
        for (int k = 0; k < 8; k++) begin
            pat_a[k*64 +: 64] = 64'h1111_1111_1111_1111 * (k + 1);
            pat_b[k*64 +: 64] = {32'hB0B0_0000 + 32'(k), 32'hDEAD_BEEF};
            pat_c[k*64 +: 64] = {16'hC0DE, 8'(k), 40'h00_A5A5_5A5A};
        end
        test_reset();
        test_full_write_read();
        test_masked_write();
        test_wrap();
        test_simul_and_busy();
        test_back_to_back();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule : tb_vram_responder
`default_nettype wire
